// File: rtl/fetch_stage.sv
// RV32I fetch stage plus IF/EX pipeline register.
// Keeps at most one instruction-memory request outstanding and honours stalls, flushes and reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_ex,
  input  logic        flush,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_ex,
  output logic [31:0] pc_ex,
  output logic        valid_ex
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]  state_q, state_d, rst_state;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_ex_q, pc_ex_d;
  logic        valid_q, valid_d;
  logic        stall_f;
  logic        req;
  logic        deliver;
  logic [31:0] instr;

  assign stall_f = stall_if | stall_ex;

  // A request may still be in flight at reset; its response must be swallowed.
  always_comb begin
    if (state_q == WAIT || state_q == DISCARD) rst_state = DISCARD;
    else                                        rst_state = FETCH;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    req     = 1'b0;
    deliver = 1'b0;
    instr   = hold_q;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (flush) begin
          pc_d    = br_target;
          state_d = DISCARD;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            pc_d    = br_target;
            state_d = FETCH;
          end else if (stall_f) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            deliver = 1'b1;
            instr   = imem_rdata;
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end else if (flush) begin
          pc_d    = br_target;
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = br_target;
          state_d = FETCH;
        end else if (!stall_f) begin
          deliver = 1'b1;
          instr   = hold_q;
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      default: begin
        if (flush) pc_d = br_target;
        if (imem_rvalid) state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    ir_d    = ir_q;
    pc_ex_d = pc_ex_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = NOP;
      valid_d = 1'b0;
    end else if (stall_ex) begin
      ir_d    = ir_q;
    end else if (deliver) begin
      ir_d    = instr;
      pc_ex_d = pc_q;
      valid_d = 1'b1;
    end else begin
      ir_d    = NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= rst_state;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
      ir_q    <= NOP;
      pc_ex_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      ir_q    <= ir_d;
      pc_ex_q <= pc_ex_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req  = req & ~rst;
  assign imem_addr = pc_q;
  assign IR_ex     = ir_q;
  assign pc_ex     = pc_ex_q;
  assign valid_ex  = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable single-outstanding memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_ex, flush;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'd0;
  logic [31:0] IR_ex, pc_ex;
  logic        valid_ex;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cnt   = 0;
  logic        req_s;
  logic [31:0] addr_s, paddr;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_if   (stall_if),
    .stall_ex   (stall_ex),
    .flush      (flush),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .IR_ex      (IR_ex),
    .pc_ex      (pc_ex),
    .valid_ex   (valid_ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: request seen at edge k answers during the cycle after edge k+lat-1.
  always @(posedge clk) begin
    req_s  = imem_req;
    addr_s = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (req_s) begin
      cnt   = lat;
      paddr = addr_s;
    end
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(paddr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_ex(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic v);
    chk({tag, ".ir"}, IR_ex, ir);
    chk({tag, ".pc"}, pc_ex, pc);
    chk({tag, ".valid"}, {31'd0, valid_ex}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; stall_if = 1'b0; stall_ex = 1'b0; flush = 1'b0; br_target = 32'd0;
    step(); step();
    chk_ex("reset", NOP, 32'd0, 1'b0);
    chk_req("reset", 1'b0, 32'd0);
    rst = 1'b0;
    #1 chk_req("A", 1'b1, 32'h0);
    step(); chk_req("B", 1'b0, 0); chk("B.rvalid", {31'd0, imem_rvalid}, 32'd1);
    step(); chk_ex("C", word(0), 32'h0, 1'b1); chk_req("C", 1'b1, 32'h4);
    step(); chk_ex("D", NOP, 32'h0, 1'b0); chk_req("D", 1'b0, 0);
    step(); chk_ex("E", word(4), 32'h4, 1'b1); chk_req("E", 1'b1, 32'h8);
    // stall_ex covers the pc=8 response cycle; stall_if keeps it in HOLD afterwards
    stall_ex = 1'b1; stall_if = 1'b1;
    step(); chk_ex("F", word(4), 32'h4, 1'b1); chk_req("F", 1'b0, 0);
    step(); chk_ex("G", word(4), 32'h4, 1'b1); chk_req("G", 1'b0, 0);
    stall_ex = 1'b0;
    step(); chk_ex("H", NOP, 32'h4, 1'b0); chk_req("H", 1'b0, 0);
    step(); chk_ex("I", NOP, 32'h4, 1'b0); chk_req("I", 1'b0, 0);
    stall_if = 1'b0;
    step(); chk_ex("J", word(8), 32'h8, 1'b1); chk_req("J", 1'b1, 32'hC);
    step(); chk_ex("K", NOP, 32'h8, 1'b0); chk_req("K", 1'b0, 0);
    step(); chk_ex("L", word(12), 32'hC, 1'b1); chk_req("L", 1'b1, 32'h10);
    lat = 3;
    step(); chk_req("M", 1'b0, 0);
    flush = 1'b1; br_target = 32'h100;
    step(); chk_ex("N", NOP, 32'hC, 1'b0); chk_req("N", 1'b0, 0);
    flush = 1'b0;
    step(); chk("O.rvalid", {31'd0, imem_rvalid}, 32'd1); chk_req("O", 1'b0, 0);
    step(); chk_ex("P", NOP, 32'hC, 1'b0); chk_req("P", 1'b1, 32'h100);
    lat = 1;
    step(); chk_req("Q", 1'b0, 0);
    step(); chk_ex("R", word(32'h100), 32'h100, 1'b1); chk_req("R", 1'b1, 32'h104);
    step(); chk("S.rvalid", {31'd0, imem_rvalid}, 32'd1);
    flush = 1'b1; br_target = 32'h40;
    step(); chk_ex("T", NOP, 32'h100, 1'b0); chk_req("T", 1'b1, 32'h40);
    flush = 1'b0; lat = 4;
    step(); chk_req("U", 1'b0, 0);
    rst = 1'b1;
    step(); chk_ex("V", NOP, 32'h0, 1'b0); chk_req("V", 1'b0, 0);
    rst = 1'b0; lat = 1;
    #1 chk_req("V2", 1'b0, 0);
    step(); chk_req("W", 1'b0, 0);
    step(); chk("X.rvalid", {31'd0, imem_rvalid}, 32'd1); chk_req("X", 1'b0, 0);
    step(); chk_req("Y", 1'b1, 32'h0);
    flush = 1'b1; br_target = 32'hFFFF_FFFC;
    step(); chk_req("Z", 1'b0, 0); chk_ex("Z", NOP, 32'h0, 1'b0);
    flush = 1'b0;
    step(); chk_req("AA", 1'b1, 32'hFFFF_FFFC);
    step(); chk_req("AB", 1'b0, 0);
    step(); chk_ex("AC", word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
    chk_req("AC", 1'b1, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage and IF/EX pipeline register of the RV32I pipeline.
- Generates the PC and issues one instruction-memory request at a time.
- Captures the returned instruction and delivers IR_ex/pc_ex to the execute stage.
- Obeys stall_if, stall_ex and flush from the forwarding/stall unit, including redirects while a fetch is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IR_ex.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC and the fetched instruction.
- stall_ex  in  1  hold IR_ex, pc_ex and valid_ex; implies stall_if (stall_ex=1 is treated as stall_if=1).
- flush  in  1  branch taken: redirect PC to br_target and bubble IF/EX.
- br_target  in  32  redirect address, sampled when flush=1.
- imem_req  out  1  request strobe, single-cycle pulse.
- imem_addr  out  32  request address, equal to pc.
- imem_rvalid  in  1  response valid; at least 1 cycle after imem_req; exactly one response per request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- IR_ex  out  32  instruction in the EX stage.
- pc_ex  out  32  PC of IR_ex.
- valid_ex  out  1  IR_ex is a real instruction; 0 means bubble.

Behaviour:
Reset values:
- pc=RESET_PC; IR_ex=NOP; pc_ex=0; valid_ex=0.
- imem_req is forced 0 while rst=1.

Reset state selection:
- If the state at rst is WAIT or DISCARD, next state is DISCARD, so the orphaned response is dropped.
- Otherwise next state is FETCH.

FSM, states FETCH, WAIT, HOLD, DISCARD:
- FETCH
  - imem_req=1, imem_addr=pc; next state WAIT.
  - If flush=1: pc<=br_target and next state is DISCARD. The request issued this cycle is stale.
- WAIT (imem_req=0)
  - rvalid & flush: drop rdata; pc<=br_target; next FETCH.
  - rvalid & stall_if: hold_buf<=rdata; next HOLD.
  - rvalid otherwise: deliver rdata with pc; pc<=pc+4; next FETCH.
  - No rvalid & flush: pc<=br_target; next DISCARD.
- HOLD
  - flush: drop hold_buf; pc<=br_target; next FETCH.
  - No stall_if: deliver hold_buf with pc; pc<=pc+4; next FETCH.
  - Otherwise stay in HOLD.
- DISCARD
  - Wait for rvalid, drop it, then next FETCH.
  - flush while in DISCARD: pc<=br_target; stay in DISCARD.

IF/EX register, priority in this order:
1. rst
2. flush: IR_ex<=NOP, valid_ex<=0
3. stall_ex: hold all
4. deliver: IR_ex<=instr, pc_ex<=pc, valid_ex<=1
5. otherwise bubble: IR_ex<=NOP, valid_ex<=0; pc_ex holds

Arithmetic and timing:
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- br_target is used unmodified.
- Throughput is one instruction per 2 cycles with 1-cycle memory.
- Latency from request to IR_ex is response latency + 1 cycle.
- Never more than one outstanding request.
- imem_req is never asserted in WAIT, HOLD or DISCARD.

Test Plan:
- Reset, 1-cycle memory returning pc-tagged words.
  - imem_addr sequence is 0, 4, 8 on every other cycle.
  - IR_ex follows it one cycle after each rvalid, with valid_ex=1 and bubbles between.
- stall_if=1 for 3 cycles, asserted on the rvalid cycle of the fetch at pc=8.
  - Instruction is held in HOLD; no imem_req; IR_ex=NOP and valid_ex=0 throughout.
  - After release, IR_ex=word@8 and pc_ex=8; next request is to 12.
- stall_ex=1 for 2 cycles, asserted while IR_ex=word@4.
  - IR_ex, pc_ex and valid_ex are unchanged for 2 cycles.
  - No new delivery occurs.
- flush=1 with br_target=0x100 in WAIT, memory latency 3.
  - Late response is discarded and IR_ex=NOP.
  - Next imem_addr=0x100; first delivered pc_ex=0x100.
- flush coincident with rvalid in WAIT (br_target=0x40).
  - rdata is dropped and valid_ex=0.
  - Next cycle imem_req=1 with imem_addr=0x40.
- rst asserted in WAIT, response arrives 2 cycles after rst deasserts.
  - Response is dropped.
  - First request after it is to RESET_PC.
  - pc=0xFFFF_FFFC advances to 0 without an X.
